mc_ctrl_fsm: RTL and testbench
==============================

Name: mc_ctrl_fsm

Overview:
- Multicycle MIPS main controller. Sequences the shared datapath (one memory, one ALU, IR, register file, PC) over 3–5 cycles per instruction.
- Emits the 2-bit aluop consumed by the ALU decoder: 00 add, 01 sub, 10 R-type funct, 11 I-type opcode.
- Adds a memory-ready stall handshake and an illegal-opcode flag.

Parameters:
- STATE_W, 4, state register width; fixed encoding below.

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- opcode  in  6  IR[31:26]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes access this cycle
- memwrite  out  1  memory write strobe
- irwrite  out  1  IR load enable
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- regdst  out  1  write register select: 1 = rd, 0 = rt
- memtoreg  out  1  write-back select: 1 = data register, 0 = ALUOut
- regwrite  out  1  register-file write enable
- alusrca  out  1  ALU A select: 0 = PC, 1 = A register
- alusrcb  out  2  ALU B select: 00 = B register, 01 = 4, 10 = sign-extended immediate, 11 = shifted immediate
- pcsrc  out  2  PC source: 00 = ALU, 01 = ALUOut, 10 = jump target
- aluop  out  2  to the ALU decoder
- pcen  out  1  PC load enable = pcwrite | (branch & branch condition)
- illegal_op  out  1  one-cycle pulse on an unsupported opcode
- state  out  4  current state, for debug

Behaviour:
- Asynchronous reset (reset_n=0): state <= FETCH immediately; every control output forced 0 while reset_n=0, including state? no: state reads FETCH=0. First FETCH action occurs on the first edge after release.
- State encoding:
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5
  - RTYPEEX=6, RTYPEWB=7, BEQEX=8, IEX=9, IWB=10, JEX=11
- Outputs are a Moore decode of state, except FETCH strobes, which are gated by mem_ready. Unlisted outputs are 0.
- FETCH: iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00.
  - irwrite=mem_ready; pcen=mem_ready.
  - Hold while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE: alusrca=0, alusrcb=11, aluop=00 (branch target into ALUOut). Next state by opcode:
  - 100011 / 101011 -> MEMADR
  - 000000 -> RTYPEEX
  - 000100 -> BEQEX
  - 001000 / 001101 -> IEX
  - 000010 -> JEX
  - any other -> FETCH, with illegal_op=1 for exactly this cycle
- MEMADR: alusrca=1, alusrcb=10, aluop=00. Next: lw -> MEMRD, sw -> MEMWR.
- MEMRD: iord=1. Hold until mem_ready=1, then -> MEMWB.
- MEMWB: regdst=0, memtoreg=1, regwrite=1. -> FETCH.
- MEMWR: iord=1, memwrite=1 held for every cycle spent in the state. Exit to FETCH on the cycle mem_ready=1.
- RTYPEEX: alusrca=1, alusrcb=00, aluop=10. -> RTYPEWB.
- RTYPEWB: regdst=1, memtoreg=0, regwrite=1. -> FETCH.
- BEQEX: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, pcen=zero. -> FETCH.
- IEX (addi and ori): alusrca=1, alusrcb=10, aluop=11, so the ALU decoder selects the operation by opcode. -> IWB.
- IWB: regdst=0, memtoreg=0, regwrite=1. -> FETCH.
- JEX: pcsrc=10, pcen=1. -> FETCH.
- CPI: R-type 4, I-type 4, beq 3, j 3, lw 5, sw 4; each memory wait cycle adds 1.
- Unused encodings 12–15: all outputs 0, next state FETCH.
- Reset asserted mid-instruction aborts it at once: no partial regwrite or memwrite after reset_n falls.
- opcode is sampled only in DECODE and MEMADR; the IR is stable there because irwrite=0.

Optional Feature:
- Macro MC_BNE_EN.
- Defined:
  - Opcode 000101 (bne) decodes DECODE -> BEQEX, not illegal.
  - In BEQEX, pcen = zero for beq and ~zero for bne. The opcode is registered in DECODE to pick the polarity.
- Undefined: 000101 is illegal (illegal_op pulse, return to FETCH); BEQEX uses pcen=zero only.

Test Plan:
- Reset: reset_n=0 mid-RTYPEEX -> state=0 and all outputs 0 asynchronously. After release with mem_ready=1, irwrite=1 and pcen=1 on the first cycle.
- R-type add, mem_ready=1: states 0,1,6,7,0. aluop=10 in state 6; regwrite=1 and regdst=1 in state 7.
- lw with mem_ready low 2 cycles in MEMRD: states 0,1,2,3,3,3,4,0. iord=1 throughout state 3; regwrite=1 and memtoreg=1 in state 4.
- sw with mem_ready=1: states 0,1,2,5,0. memwrite=1 for exactly 1 cycle.
- beq: zero=1 gives pcen=1 and pcsrc=01 in state 8; zero=0 gives pcen=0. ori (001101) gives aluop=11 in state 9 and regwrite=1 in state 10.
- Opcode 111111 in DECODE: illegal_op=1 for exactly 1 cycle, next state 0, no regwrite or memwrite. With MC_BNE_EN, opcode 000101 and zero=0 give pcen=1 in state 8.

Source files
------------

// File: rtl/mc_ctrl_fsm.sv
// Multicycle MIPS main controller: sequences the shared memory/ALU/IR/regfile/PC datapath.
// Latency: 3-5 cycles per instruction plus one cycle per memory wait (mem_ready low).
// Backpressure: FETCH, MEMRD and MEMWR hold until mem_ready; optional bne support via MC_BNE_EN.
module mc_ctrl_fsm #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [5:0]         opcode,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               memwrite,
  output logic               irwrite,
  output logic               iord,
  output logic               regdst,
  output logic               memtoreg,
  output logic               regwrite,
  output logic               alusrca,
  output logic [1:0]         alusrcb,
  output logic [1:0]         pcsrc,
  output logic [1:0]         aluop,
  output logic               pcen,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state
);

  typedef enum logic [STATE_W-1:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_IEX     = 4'd9,
    S_IWB     = 4'd10,
    S_JEX     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
`ifdef MC_BNE_EN
  localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

  state_t state_q, state_d;

  // State register; reset returns to FETCH immediately, aborting any instruction.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_FETCH;
    else          state_q <= state_d;
  end

`ifdef MC_BNE_EN
  logic bne_q;
  // Remember branch polarity while the opcode is known to be stable in DECODE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                  bne_q <= 1'b0;
    else if (state_q == S_DECODE)  bne_q <= (opcode == OP_BNE);
  end
`endif

  // Next-state and Moore output decode; everything is forced low while reset is held.
  always_comb begin
    state_d    = state_q;
    memwrite   = 1'b0;
    irwrite    = 1'b0;
    iord       = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    regwrite   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    aluop      = 2'b00;
    pcen       = 1'b0;
    illegal_op = 1'b0;
    if (reset_n) begin
      case (state_q)
        S_FETCH: begin
          alusrcb = 2'b01;
          irwrite = mem_ready;
          pcen    = mem_ready;
          if (mem_ready) state_d = S_DECODE;
        end
        S_DECODE: begin
          alusrcb = 2'b11;
          case (opcode)
            OP_LW, OP_SW:     state_d = S_MEMADR;
            OP_RTYPE:         state_d = S_RTYPEEX;
            OP_BEQ:           state_d = S_BEQEX;
`ifdef MC_BNE_EN
            OP_BNE:           state_d = S_BEQEX;
`endif
            OP_ADDI, OP_ORI:  state_d = S_IEX;
            OP_J:             state_d = S_JEX;
            default: begin
              state_d    = S_FETCH;
              illegal_op = 1'b1;
            end
          endcase
        end
        S_MEMADR: begin
          alusrca = 1'b1;
          alusrcb = 2'b10;
          // Only lw/sw reach here; anything else simply restarts fetch.
          if (opcode == OP_LW)      state_d = S_MEMRD;
          else if (opcode == OP_SW) state_d = S_MEMWR;
          else                      state_d = S_FETCH;
        end
        S_MEMRD: begin
          iord = 1'b1;
          if (mem_ready) state_d = S_MEMWB;
        end
        S_MEMWB: begin
          memtoreg = 1'b1;
          regwrite = 1'b1;
          state_d  = S_FETCH;
        end
        S_MEMWR: begin
          iord     = 1'b1;
          memwrite = 1'b1;
          if (mem_ready) state_d = S_FETCH;
        end
        S_RTYPEEX: begin
          alusrca = 1'b1;
          aluop   = 2'b10;
          state_d = S_RTYPEWB;
        end
        S_RTYPEWB: begin
          regdst   = 1'b1;
          regwrite = 1'b1;
          state_d  = S_FETCH;
        end
        S_BEQEX: begin
          alusrca = 1'b1;
          aluop   = 2'b01;
          pcsrc   = 2'b01;
`ifdef MC_BNE_EN
          pcen    = bne_q ? ~zero : zero;
`else
          pcen    = zero;
`endif
          state_d = S_FETCH;
        end
        S_IEX: begin
          alusrca = 1'b1;
          alusrcb = 2'b10;
          aluop   = 2'b11;
          state_d = S_IWB;
        end
        S_IWB: begin
          regwrite = 1'b1;
          state_d  = S_FETCH;
        end
        S_JEX: begin
          pcsrc   = 2'b10;
          pcen    = 1'b1;
          state_d = S_FETCH;
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed bench for mc_ctrl_fsm: walks each instruction class through its state sequence.
// Inputs change on the falling edge; outputs are checked 1 time unit later.
// Memory stalls are injected in FETCH and MEMRD to exercise the hold behaviour.
module tb_mc_ctrl_fsm;

  logic       clk;
  logic       reset_n;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       memwrite, irwrite, iord, regdst, memtoreg, regwrite, alusrca, pcen, illegal_op;
  logic [1:0] alusrcb, pcsrc, aluop;
  logic [3:0] state;

  int n_chk  = 0;
  int n_pass = 0;

  mc_ctrl_fsm #(.STATE_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .memwrite(memwrite), .irwrite(irwrite), .iord(iord), .regdst(regdst),
    .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb),
    .pcsrc(pcsrc), .aluop(aluop), .pcen(pcen), .illegal_op(illegal_op), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {memwrite,irwrite,iord,regdst,memtoreg,regwrite,alusrca,alusrcb,pcsrc,aluop,pcen,illegal_op}
  logic [14:0] ctl;
  assign ctl = {memwrite, irwrite, iord, regdst, memtoreg, regwrite, alusrca,
                alusrcb, pcsrc, aluop, pcen, illegal_op};

  localparam logic [14:0] C_ZERO  = 15'b0_0_0_0_0_0_0_00_00_00_0_0;
  localparam logic [14:0] C_F_RDY = 15'b0_1_0_0_0_0_0_01_00_00_1_0;
  localparam logic [14:0] C_F_STL = 15'b0_0_0_0_0_0_0_01_00_00_0_0;
  localparam logic [14:0] C_DEC   = 15'b0_0_0_0_0_0_0_11_00_00_0_0;
  localparam logic [14:0] C_DEC_I = 15'b0_0_0_0_0_0_0_11_00_00_0_1;
  localparam logic [14:0] C_MADR  = 15'b0_0_0_0_0_0_1_10_00_00_0_0;
  localparam logic [14:0] C_MRD   = 15'b0_0_1_0_0_0_0_00_00_00_0_0;
  localparam logic [14:0] C_MWB   = 15'b0_0_0_0_1_1_0_00_00_00_0_0;
  localparam logic [14:0] C_MWR   = 15'b1_0_1_0_0_0_0_00_00_00_0_0;
  localparam logic [14:0] C_REX   = 15'b0_0_0_0_0_0_1_00_00_10_0_0;
  localparam logic [14:0] C_RWB   = 15'b0_0_0_1_0_1_0_00_00_00_0_0;
  localparam logic [14:0] C_BQ_T  = 15'b0_0_0_0_0_0_1_00_01_01_1_0;
  localparam logic [14:0] C_BQ_N  = 15'b0_0_0_0_0_0_1_00_01_01_0_0;
  localparam logic [14:0] C_IEX   = 15'b0_0_0_0_0_0_1_10_00_11_0_0;
  localparam logic [14:0] C_IWB   = 15'b0_0_0_0_0_1_0_00_00_00_0_0;
  localparam logic [14:0] C_JEX   = 15'b0_0_0_0_0_0_0_00_10_00_1_0;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;
  localparam logic [5:0] OP_ORI = 6'b001101;
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_BAD = 6'b111111;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic look(input string tag, input logic [3:0] es, input logic [14:0] ec);
    chk({tag, " state"}, 32'(state), 32'(es));
    chk({tag, " ctl"},   32'(ctl),   32'(ec));
  endtask

  // One cycle: drive inputs on the falling edge, then check the current state's outputs.
  task automatic cyc(input string tag, input logic [5:0] op, input logic z, input logic mr,
                     input logic [3:0] es, input logic [14:0] ec);
    @(negedge clk);
    opcode = op; zero = z; mem_ready = mr;
    #1;
    look(tag, es, ec);
  endtask

  initial begin
    reset_n = 1'b0; opcode = OP_R; zero = 1'b0; mem_ready = 1'b1;
    #2;
    look("por", 4'd0, C_ZERO);

    @(negedge clk);
    reset_n = 1'b1;
    #1;
    look("rel_fetch", 4'd0, C_F_RDY);

    // R-type add
    cyc("r_dec", OP_R, 1'b0, 1'b1, 4'd1, C_DEC);
    cyc("r_ex",  OP_R, 1'b0, 1'b1, 4'd6, C_REX);
    cyc("r_wb",  OP_R, 1'b0, 1'b1, 4'd7, C_RWB);

    // lw with two wait cycles in MEMRD
    cyc("lw_f",   OP_LW, 1'b0, 1'b1, 4'd0, C_F_RDY);
    cyc("lw_dec", OP_LW, 1'b0, 1'b1, 4'd1, C_DEC);
    cyc("lw_adr", OP_LW, 1'b0, 1'b1, 4'd2, C_MADR);
    cyc("lw_rd0", OP_LW, 1'b0, 1'b0, 4'd3, C_MRD);
    cyc("lw_rd1", OP_LW, 1'b0, 1'b0, 4'd3, C_MRD);
    cyc("lw_rd2", OP_LW, 1'b0, 1'b1, 4'd3, C_MRD);
    cyc("lw_wb",  OP_LW, 1'b0, 1'b1, 4'd4, C_MWB);

    // sw, memory ready at once
    cyc("sw_f",   OP_SW, 1'b0, 1'b1, 4'd0, C_F_RDY);
    cyc("sw_dec", OP_SW, 1'b0, 1'b1, 4'd1, C_DEC);
    cyc("sw_adr", OP_SW, 1'b0, 1'b1, 4'd2, C_MADR);
    cyc("sw_wr",  OP_SW, 1'b0, 1'b1, 4'd5, C_MWR);

    // beq taken, then not taken
    cyc("bt_f",   OP_BEQ, 1'b1, 1'b1, 4'd0, C_F_RDY);
    cyc("bt_dec", OP_BEQ, 1'b1, 1'b1, 4'd1, C_DEC);
    cyc("bt_ex",  OP_BEQ, 1'b1, 1'b1, 4'd8, C_BQ_T);
    cyc("bn_f",   OP_BEQ, 1'b0, 1'b1, 4'd0, C_F_RDY);
    cyc("bn_dec", OP_BEQ, 1'b0, 1'b1, 4'd1, C_DEC);
    cyc("bn_ex",  OP_BEQ, 1'b0, 1'b1, 4'd8, C_BQ_N);

    // ori
    cyc("ori_f",   OP_ORI, 1'b0, 1'b1, 4'd0, C_F_RDY);
    cyc("ori_dec", OP_ORI, 1'b0, 1'b1, 4'd1, C_DEC);
    cyc("ori_ex",  OP_ORI, 1'b0, 1'b1, 4'd9, C_IEX);
    cyc("ori_wb",  OP_ORI, 1'b0, 1'b1, 4'd10, C_IWB);

    // j with one fetch stall cycle
    cyc("j_fstl", OP_J, 1'b0, 1'b0, 4'd0, C_F_STL);
    cyc("j_f",    OP_J, 1'b0, 1'b1, 4'd0, C_F_RDY);
    cyc("j_dec",  OP_J, 1'b0, 1'b1, 4'd1, C_DEC);
    cyc("j_ex",   OP_J, 1'b0, 1'b1, 4'd11, C_JEX);

    // illegal opcode: one-cycle pulse, straight back to FETCH
    cyc("ill_f",   OP_BAD, 1'b0, 1'b1, 4'd0, C_F_RDY);
    cyc("ill_dec", OP_BAD, 1'b0, 1'b1, 4'd1, C_DEC_I);
    cyc("ill_ret", OP_BAD, 1'b0, 1'b1, 4'd0, C_F_RDY);

    // bne: branch with inverted polarity when enabled, illegal otherwise
    cyc("bne_dec", OP_BNE, 1'b0, 1'b1, 4'd1,
`ifdef MC_BNE_EN
        C_DEC);
    cyc("bne_ex",  OP_BNE, 1'b0, 1'b1, 4'd8, C_BQ_T);
`else
        C_DEC_I);
`endif
    cyc("bne_ret", OP_R, 1'b0, 1'b1, 4'd0, C_F_RDY);

    // reset asserted mid-RTYPEEX takes effect without a clock edge
    cyc("rr_dec", OP_R, 1'b0, 1'b1, 4'd1, C_DEC);
    cyc("rr_ex",  OP_R, 1'b0, 1'b1, 4'd6, C_REX);
    #2;
    reset_n = 1'b0;
    #1;
    look("mid_rst", 4'd0, C_ZERO);
    @(negedge clk);
    #1;
    look("rst_hold", 4'd0, C_ZERO);
    reset_n = 1'b1;
    #1;
    look("rst_rel", 4'd0, C_F_RDY);
    cyc("rst_dec", OP_R, 1'b0, 1'b1, 4'd1, C_DEC);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
